seven_seg_display_arbiter: RTL and testbench
============================================

// Module: seven_seg_display_arbiter
// PURPOSE
//  Shares the two-digit seven-segment display mux between NREQ requesters.
//  Round-robin, with a minimum dwell per owner measured in display refresh ticks.
//  Drives the 14-bit both7seg pattern into the display mux.
//  Consumes the mux's 1-cycle digit-switch pulse (sig) as its tick input.
// PARAMETERS
//  NREQ   4         number of requesters (2..8)
//  DWELL  8         ticks an owner keeps the display (>=1)
//  BLANK  14'h0000  pattern driven when no requester owns the display
// PORTS
//  clk       in   1        clock
//  rst       in   1        reset; synchronous, active-high
//  tick      in   1        refresh pulse from display mux, 1 cycle wide
//  req       in   NREQ     request per requester; level, held while owner wants display
//  pat       in   NREQ*14  requester i pattern at pat[i*14 +: 14] ([13:7] digit1, [6:0] digit0)
//  gnt       out  NREQ     one-hot grant, registered
//  both7seg  out  14       pattern to display mux, registered
//  busy      out  1        1 when state != IDLE
//  done      out  1        1-cycle pulse when a grant is released
// BEHAVIOUR
//  Reset: all outputs, state and counters return to reset values at the next clk edge.
//  - Reset values: gnt=0, both7seg=BLANK, busy=0, done=0, state=IDLE, ptr=0, dwell_cnt=0.
//  - Reset mid-OWN aborts the grant. No done pulse is issued.
//  States and transitions:
//  - IDLE: if |req, select the first set req[k], searching k=ptr,ptr+1,... mod NREQ.
//    Next edge: state=OWN, gnt=1<<k, owner=k, dwell_cnt=0.
//  - IDLE with no request: outputs stay at reset values.
//  - OWN: every cycle both7seg <= pat[owner] (pattern change visible 1 cycle later).
//    On tick, dwell_cnt increments.
//    Exit condition: tick while dwell_cnt==DWELL-1, OR req[owner]==0.
//    On exit: next edge state=RELEASE.
//  - RELEASE: one cycle with gnt=0, done=1, both7seg=BLANK.
//    Then ptr <= (owner+1) mod NREQ (wraps NREQ-1 -> 0); next state IDLE.
//  Latency and spacing:
//  - req rise in IDLE -> gnt at next edge.
//  - Minimum gap between consecutive grants: 2 cycles (RELEASE, IDLE).
//  Boundary rules:
//  - tick arriving in IDLE or RELEASE is ignored.
//  - Owner drop and final tick in the same cycle: single release, single done pulse.
//  - Requests from non-owners during OWN are not latched. They must be held until granted.
//  - dwell_cnt width is $clog2(DWELL+1). It saturates at DWELL-1, never wraps.
//  - Only the owner's pat slice reaches both7seg. Other slices are don't-care.
// CONFIGURATION
//  Macro SEVEN_ARB_PREEMPT_EN.
//  - Defined: requester 0 is high priority.
//    - In IDLE, req[0]=1 wins regardless of ptr.
//    - In OWN with owner!=0, req[0]=1 forces RELEASE at the next edge regardless of dwell.
//    - A grant to requester 0 leaves ptr unchanged.
//  - Undefined: requester 0 is an ordinary round-robin participant. No preemption logic.
// TESTING
//  1. rst=1 for 2 cycles mid-operation -> gnt=0, both7seg=14'h0000, busy=0, done=0.
//     First grant after reset goes to index 0 when req=4'b1111.
//  2. req=4'b0100, pat[2]=14'h1ABC, DWELL=8, tick every 10 cycles ->
//     gnt=4'b0100 one cycle after req; both7seg=14'h1ABC the following cycle.
//     Release after the 8th tick; done pulses one cycle; gnt=0.
//  3. req=4'b1111 held continuously -> grant order 0,1,2,3,0.
//     Each grant lasts 8 ticks; 2-cycle gaps between grants.
//  4. Owner 1 drops req after 3 ticks -> RELEASE next edge, done=1 for one cycle.
//     Then the next grant goes to requester 2 if req[2]=1.
//  5. pat[owner] changes 14'h0011 -> 14'h3F7F during OWN ->
//     both7seg follows one cycle later; gnt is unchanged.
//  6. SEVEN_ARB_PREEMPT_EN defined, owner=1, req[0] rises after 2 ticks ->
//     RELEASE next edge, then gnt=4'b0001.
//     Macro undefined: requester 0 waits for the full dwell of owner 1, then requester 2/3 per ptr.

Source files
------------

// File: rtl/seven_seg_display_arbiter.sv
// Round-robin owner arbiter for the shared two-digit seven-segment display mux.
// Optional macro SEVEN_ARB_PREEMPT_EN gives requester 0 preemptive priority.
module seven_seg_display_arbiter #(
  parameter int          NREQ  = 4,
  parameter int          DWELL = 8,
  parameter logic [13:0] BLANK = 14'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*14-1:0] pat,
  output logic [NREQ-1:0]   gnt,
  output logic [13:0]       both7seg,
  output logic              busy,
  output logic              done
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(DWELL + 1);
  localparam logic [IW:0] NR = (IW + 1)'(NREQ);

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    RELEASE
  } state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [13:0]       seg_q, seg_d;
  logic              done_q, done_d;

  logic [2*NREQ-1:0] rot;
  logic [IW-1:0]     off;
  logic [IW:0]       sum;
  logic [IW-1:0]     pick;
  logic [13:0]       opat;
  logic              own_req;
  logic              last;
  logic              pre;
  logic              leave;

  // Rotate requests so the search always starts at ptr.
  always_comb begin
    rot = {req, req} >> ptr_q;
    off = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (rot[j]) off = IW'(j);
    end
    sum = {1'b0, ptr_q} + {1'b0, off};
    if (sum >= NR) sum = sum - NR;
    pick = sum[IW-1:0];
`ifdef SEVEN_ARB_PREEMPT_EN
    if (req[0]) pick = '0;
`endif
  end

  always_comb begin
    opat = BLANK;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == IW'(i)) opat = pat[i*14 +: 14];
    end
  end

  always_comb begin
    own_req = |(req & gnt_q);
    last    = tick && (cnt_q == CW'(DWELL - 1));
`ifdef SEVEN_ARB_PREEMPT_EN
    pre     = req[0] && !gnt_q[0];
`else
    pre     = 1'b0;
`endif
    leave   = last || !own_req || pre;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|req) state_d = OWN;
      OWN:     if (leave) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    seg_d   = seg_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        seg_d = BLANK;
        if (|req) begin
          owner_d = pick;
          gnt_d   = NREQ'(1) << pick;
          cnt_d   = '0;
        end
      end
      OWN: begin
        if (leave) begin
          gnt_d  = '0;
          seg_d  = BLANK;
          done_d = 1'b1;
        end else begin
          seg_d = opat;
          if (tick) cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        gnt_d = '0;
        seg_d = BLANK;
        if (owner_q == IW'(NREQ - 1)) ptr_d = '0;
        else ptr_d = owner_q + 1'b1;
`ifdef SEVEN_ARB_PREEMPT_EN
        if (owner_q == '0) ptr_d = ptr_q;
`endif
      end
      default: begin
        gnt_d = '0;
        seg_d = BLANK;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      seg_q   <= BLANK;
      done_q  <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      seg_q   <= seg_d;
      done_q  <= done_d;
    end
  end

  assign gnt      = gnt_q;
  assign both7seg = seg_q;
  assign done     = done_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_seven_seg_display_arbiter.sv
// Randomized bench for seven_seg_display_arbiter with an ownership-level model
// plus directed grant-order, dwell, pattern-follow and reset checks.
module tb_seven_seg_display_arbiter;

  localparam int NREQ  = 4;
  localparam int DWELL = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic [3:0]  req = '0;
  logic [55:0] pat = '0;
  logic [3:0]  gnt;
  logic [13:0] both7seg;
  logic        busy;
  logic        done;

  seven_seg_display_arbiter #(
    .NREQ (NREQ),
    .DWELL(DWELL),
    .BLANK(14'h0000)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .req     (req),
    .pat     (pat),
    .gnt     (gnt),
    .both7seg(both7seg),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int npass = 0;
  int ntot  = 0;
  int ncyc  = 0;

  // Model: owner = -1 means nobody holds the display; rel marks the
  // single release cycle that follows every grant.
  int         m_owner = -1;
  bit         m_rel   = 1'b0;
  int         m_ptr   = 0;
  int         m_ticks = 0;
  logic [3:0]  e_gnt  = '0;
  logic [13:0] e_seg  = '0;
  bit          e_done = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, act, exp, ncyc);
  endtask

  function automatic int first_req(input logic [3:0] r, input int p);
    int k;
    k = -1;
    for (int j = NREQ - 1; j >= 0; j--)
      if (r[(p + j) % NREQ]) k = (p + j) % NREQ;
`ifdef SEVEN_ARB_PREEMPT_EN
    if (r[0]) k = 0;
`endif
    return k;
  endfunction

  task automatic model_step();
    bit pre;
    if (rst) begin
      m_owner = -1; m_rel = 0; m_ptr = 0; m_ticks = 0;
      e_gnt = '0; e_seg = '0; e_done = 0;
    end else if (m_rel) begin
      m_rel = 0; e_done = 0;
`ifdef SEVEN_ARB_PREEMPT_EN
      if (m_owner != 0) m_ptr = (m_owner + 1) % NREQ;
`else
      m_ptr = (m_owner + 1) % NREQ;
`endif
      m_owner = -1;
    end else if (m_owner < 0) begin
      if (req != 0) begin
        m_owner = first_req(req, m_ptr);
        e_gnt = 4'(1 << m_owner);
        m_ticks = 0;
      end
    end else begin
      pre = 0;
`ifdef SEVEN_ARB_PREEMPT_EN
      pre = req[0] && m_owner != 0;
`endif
      if (tick) m_ticks++;
      if (m_ticks == DWELL || !req[m_owner] || pre) begin
        m_rel = 1; e_gnt = '0; e_seg = '0; e_done = 1;
      end else begin
        e_seg = pat[m_owner*14 +: 14];
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    ncyc++;
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("both7seg", 32'(both7seg), 32'(e_seg));
    chk("done", 32'(done), 32'(e_done));
    chk("busy", 32'(busy), 32'(m_owner >= 0 || m_rel));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_seg", 32'(both7seg), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    rst = 1'b0;
  endtask

  int order[$];
  int gap, len, ntk, idx;
  logic [3:0] prevg;
  int exp_order[5];

  initial begin
    // Grant rotation with all requests held and a tick every cycle.
    do_reset();
    req = 4'b1111;
    tick = 1'b1;
    pat = {$urandom, $urandom};
    prevg = '0; gap = 0; len = 0;
    for (int c = 0; c < 200 && order.size() < 5; c++) begin
      cyc();
      if (gnt != 0) begin
        if (prevg == 0) begin
          idx = 0;
          for (int b = 0; b < 4; b++) if (gnt[b]) idx = b;
          order.push_back(idx);
          if (order.size() > 1) chk("gap", 32'(gap), 32'd2);
          len = 0;
        end
        len++;
        gap = 0;
      end else begin
        if (prevg != 0) chk("dwell_len", 32'(len), 32'(DWELL));
        gap++;
      end
      prevg = gnt;
    end
`ifdef SEVEN_ARB_PREEMPT_EN
    exp_order = '{0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    chk("grant_count", 32'(order.size()), 32'd5);
    foreach (order[i]) chk("grant_order", 32'(order[i]), 32'(exp_order[i]));

    // Single requester, tick every 10 cycles, pattern follow.
    tick = 1'b0;
    req = '0;
    do_reset();
    req = 4'b0100;
    pat = '0;
    pat[28 +: 14] = 14'h1ABC;
    ntk = 0;
    cyc();
    chk("gnt_latency", 32'(gnt), 32'h4);
    cyc();
    chk("seg_follow", 32'(both7seg), 32'h1ABC);
    pat[28 +: 14] = 14'h0011;
    cyc();
    chk("seg_0011", 32'(both7seg), 32'h0011);
    pat[28 +: 14] = 14'h3F7F;
    cyc();
    chk("seg_3F7F", 32'(both7seg), 32'h3F7F);
    chk("gnt_hold", 32'(gnt), 32'h4);
    for (int c = 0; c < 200 && !done; c++) begin
      tick = (ncyc % 10 == 9);
      if (tick && gnt != 0) ntk++;
      cyc();
    end
    tick = 1'b0;
    chk("done_seen", 32'(done), 32'h1);
    chk("ticks_to_release", 32'(ntk), 32'(DWELL));
    chk("gnt_released", 32'(gnt), 32'h0);
    cyc();
    chk("done_pulse", 32'(done), 32'h0);

    // Random traffic with occasional mid-operation resets.
    req = '0;
    for (int c = 0; c < 4000; c++) begin
      rst  = ($urandom % 600 == 0);
      tick = ($urandom % 3 == 0);
      for (int b = 0; b < 4; b++)
        if ($urandom % 12 == 0) req[b] = ~req[b];
      if ($urandom % 4 == 0) pat = {$urandom, $urandom};
      cyc();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
